// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//   Programmable strobe source. An accepted start launches a train of
//   num_pulses single-polarity pulses with programmable high and low widths,
//   followed by a one-cycle completion strobe. Every output is a register.
//
//   Optional build macro: PULSE_TRAIN_REPEAT_EN
//     When defined, input repeat_mode is latched with the configuration on an
//     accepted start. A latched repeat_mode=1 makes the train restart endlessly
//     (done strobes on each restart edge) until abort.
// -----------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int NUM_W = 16,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
`ifdef PULSE_TRAIN_REPEAT_EN
  input  logic             repeat_mode,
`endif
  input  logic [NUM_W-1:0] num_pulses,
  input  logic [PER_W-1:0] high_cycles,
  input  logic [PER_W-1:0] low_cycles,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_sent
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] PER_ZERO = {PER_W{1'b0}};
  localparam logic [PER_W-1:0] PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};

  // Down-counter load value for a phase: a width of 0 behaves like 1, so the
  // load value is (width-1) clamped at zero.
  function automatic logic [PER_W-1:0] phase_load(input logic [PER_W-1:0] width);
    logic [PER_W-1:0] load_v;
    if (width == PER_ZERO) begin
      load_v = PER_ZERO;
    end else begin
      load_v = width - PER_ONE;
    end
    return load_v;
  endfunction

  // State and datapath registers
  logic [1:0]       r_state;
  logic [PER_W-1:0] r_cnt;
  logic [NUM_W-1:0] r_sent;
  logic [NUM_W-1:0] r_num;
  logic [PER_W-1:0] r_high;
  logic [PER_W-1:0] r_low;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [PER_W-1:0] w_cnt_nxt;
  logic [NUM_W-1:0] w_sent_nxt;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_rep;

`ifdef PULSE_TRAIN_REPEAT_EN
  logic r_rep;

  // Latch the repeat selection together with the rest of the configuration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep <= 1'b0;
    end else if (w_accept) begin
      r_rep <= repeat_mode;
    end else begin
      r_rep <= r_rep;
    end
  end

  assign w_rep = r_rep;
`else
  assign w_rep = 1'b0;
`endif

  // abort has priority over start, so a simultaneous pair is simply dropped
  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  // Full-width unsigned comparison: the pulse just issued is the final one
  assign w_last   = (r_sent == r_num);

  // Next-state, phase counter and pulse counter decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sent_nxt  = r_sent;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (num_pulses != NUM_ZERO) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = phase_load(high_cycles);
            w_sent_nxt  = NUM_ONE;
          end else begin
            // Empty train: report completion without any pulse
            w_state_nxt = ST_FIN;
            w_cnt_nxt   = PER_ZERO;
            w_sent_nxt  = NUM_ZERO;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == PER_ZERO) begin
          if (w_last && !w_rep) begin
            // No trailing low phase after the final pulse
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = phase_load(r_low);
          end
        end else begin
          w_cnt_nxt = r_cnt - PER_ONE;
        end
      end
      ST_LOW: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == PER_ZERO) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = phase_load(r_high);
          if (w_last) begin
            // Only reachable in repeat mode: the train restarts here
            w_sent_nxt = NUM_ONE;
            w_done_nxt = 1'b1;
          end else begin
            w_sent_nxt = r_sent + NUM_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - PER_ONE;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = PER_ZERO;
      end
    endcase
  end

  // FSM state, phase counter and pulse counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= PER_ZERO;
      r_sent  <= NUM_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  // Configuration is captured only on an accepted start and held mid-train
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num  <= NUM_ZERO;
      r_high <= PER_ZERO;
      r_low  <= PER_ZERO;
    end else if (w_accept) begin
      r_num  <= num_pulses;
      r_high <= high_cycles;
      r_low  <= low_cycles;
    end else begin
      r_num  <= r_num;
      r_high <= r_high;
      r_low  <= r_low;
    end
  end

  // Output strobes decoded from the next state so they align with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pulse <= (w_state_nxt == ST_HIGH);
      r_busy  <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);
      r_done  <= w_done_nxt;
    end
  end

  assign pulse       = r_pulse;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_sent;

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//   Self-checking bench: a queue-based model expands each accepted train into
//   its per-cycle output sequence; a negedge process compares the DUT to it.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] num_pulses;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [15:0] pulses_sent;
`ifdef PULSE_TRAIN_REPEAT_EN
  logic        repeat_mode;
  assign repeat_mode = 1'b0;
`endif

  pulse_train_gen #(.NUM_W(16), .PER_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
`ifdef PULSE_TRAIN_REPEAT_EN
    .repeat_mode(repeat_mode),
`endif
    .num_pulses (num_pulses),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .pulses_sent(pulses_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pulse;
    logic        busy;
    logic        done;
    logic        fin;
    logic [15:0] sent;
  } exp_t;

  exp_t q[$];
  exp_t e_cur;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic exp_t idle_val(input logic [15:0] s);
    exp_t e;
    e = '{pulse: 1'b0, busy: 1'b0, done: 1'b0, fin: 1'b0, sent: s};
    return e;
  endfunction

  // Expand a whole train into the sequence of per-cycle outputs
  task automatic build_train(input int n, input int h, input int l);
    int he;
    int le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < he; k++) q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'(i + 1)});
      if (i < n - 1)
        for (int k = 0; k < le; k++) q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'(i + 1)});
    end
    q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'(n)});
  endtask

  // Drive one cycle of inputs, advance the model, end at the next negedge
  task automatic step(input bit st, input bit ab, input int n, input int h, input int l);
    exp_t nx;
    start       = st;
    abort       = ab;
    num_pulses  = 16'(n);
    high_cycles = 16'(h);
    low_cycles  = 16'(l);
    if (q.size() > 0) begin
      if (ab && e_cur.busy) begin
        q.delete();
        nx = idle_val(e_cur.sent);
      end else begin
        nx = q.pop_front();
      end
    end else if (e_cur.fin) begin
      nx = idle_val(e_cur.sent);
    end else if (st && !ab) begin
      build_train(n, h, l);
      nx = q.pop_front();
    end else begin
      nx = idle_val(e_cur.sent);
    end
    @(posedge clk);
    e_cur = nx;
    @(negedge clk);
  endtask

  // Compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pulse", int'(pulse), int'(e_cur.pulse));
      chk("busy", int'(busy), int'(e_cur.busy));
      chk("done", int'(done), int'(e_cur.done));
      chk("pulses_sent", int'(pulses_sent), int'(e_cur.sent));
    end
  end

  logic [12:0] pd;
  logic [12:0] pm;
  logic [7:0]  zd;
  logic [7:0]  zm;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_pulses = 16'd0;
    high_cycles = 16'd0;
    low_cycles = 16'd0;
    e_cur = idle_val(16'd0);
    repeat (3) @(negedge clk);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sent", int'(pulses_sent), 0);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 3 pulses, high 2, low 3; inputs changed and start re-pulsed mid-train
    pd = 13'd0;
    pm = 13'd0;
    step(1'b1, 1'b0, 3, 2, 3);
    pd = {pd[11:0], pulse};
    pm = {pm[11:0], e_cur.pulse};
    for (int k = 2; k <= 13; k++) begin
      step(k == 4 || k == 9, 1'b0, 9, 7, 7);
      pd = {pd[11:0], pulse};
      pm = {pm[11:0], e_cur.pulse};
    end
    chk("t1_dut_wave", int'(pd), int'(13'b1100011000110));
    chk("t1_model_wave", int'(pm), int'(13'b1100011000110));
    chk("t1_done", int'(done), 1);
    chk("t1_sent", int'(pulses_sent), 3);
    step(1'b0, 1'b0, 0, 0, 0);

    // Empty train
    step(1'b1, 1'b0, 0, 5, 5);
    chk("t2_done", int'(done), 1);
    chk("t2_busy", int'(busy), 0);
    chk("t2_sent", int'(pulses_sent), 0);
    step(1'b0, 1'b0, 0, 0, 0);

    // Zero widths behave as one cycle
    zd = 8'd0;
    zm = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      step(k == 1, 1'b0, 4, 0, 0);
      zd = {zd[6:0], pulse};
      zm = {zm[6:0], e_cur.pulse};
    end
    chk("t3_dut_wave", int'(zd), int'(8'b10101010));
    chk("t3_model_wave", int'(zm), int'(8'b10101010));
    chk("t3_done", int'(done), 1);
    chk("t3_sent", int'(pulses_sent), 4);
    step(1'b0, 1'b0, 0, 0, 0);

    // Abort during the second pulse's high phase
    step(1'b1, 1'b0, 5, 4, 4);
    for (int k = 2; k <= 10; k++) step(1'b0, 1'b0, 5, 4, 4);
    step(1'b0, 1'b1, 5, 4, 4);
    chk("t4_pulse", int'(pulse), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_sent", int'(pulses_sent), 2);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 3, 1, 1);
    chk("t4_abort_wins", int'(busy), 0);
    step(1'b1, 1'b0, 1, 1, 1);
    chk("t4_restart_pulse", int'(pulse), 1);
    chk("t4_restart_sent", int'(pulses_sent), 1);
    step(1'b0, 1'b0, 0, 0, 0);
    chk("t4_restart_done", int'(done), 1);
    step(1'b1, 1'b0, 2, 1, 1);
    chk("t4_fin_start_ignored", int'(busy), 0);

    // Asynchronous reset mid-train
    step(1'b1, 1'b0, 5, 3, 3);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5, 3, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_pulse", int'(pulse), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_sent", int'(pulses_sent), 0);
    q.delete();
    e_cur = idle_val(16'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Randomized trains, aborts and mid-train input changes
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
